logica_serial: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ULA datapath. Captures two LARGURA-bit operands and an operation code on a start pulse, then evaluates the selected bitwise function over FATIA bits per clock. It presents the registered result with a one-cycle done pulse. It is the sequential, width- and operation-generalised successor to the fixed-width combinational logic units, and it feeds the ULA result multiplexer.

---
 rtl/logica_serial.sv | 171 +++++++++++++++++
 tb/tb_logica_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logica_serial.sv
// logica_serial: multi-cycle bitwise logic unit for the ULA datapath.
// Latches A, B and OP on INICIO, then evaluates FATIA bits per clock for
// N = LARGURA/FATIA cycles. It finishes with a registered RESULTADO and a
// one-cycle PRONTO pulse.
// Optional flags: define ULA_LOGICA_FLAGS_EN to compute ZERO/PARIDADE;
// otherwise both outputs are tied low.
module logica_serial #(
    parameter int LARGURA = 16,
    parameter int FATIA   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               INICIO,
    input  logic [2:0]         OP,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    output logic               OCUPADO,
    output logic               PRONTO,
    output logic [LARGURA-1:0] RESULTADO,
    output logic               ZERO,
    output logic               PARIDADE
);

    localparam int N  = LARGURA / FATIA;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]      ULTIMO  = CW'(N - 1);
    localparam logic [LARGURA-1:0] MASCARA = LARGURA'({FATIA{1'b1}});

    typedef enum logic {
        OCIOSO      = 1'b0,
        PROCESSANDO = 1'b1
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [CW-1:0]      k_q, k_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [LARGURA-1:0] acc_q, acc_d;
    logic [LARGURA-1:0] resultado_q, resultado_d;
    logic               pronto_q, pronto_d;

    logic [31:0]        base;
    logic [FATIA-1:0]   fat_a, fat_b, fat_r;
    logic [LARGURA-1:0] acc_novo;
    logic               ultima;

`ifdef ULA_LOGICA_FLAGS_EN
    logic zero_q, zero_d;
    logic paridade_q, paridade_d;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) estado_q <= OCIOSO;
        else     estado_q <= estado_d;
    end

    // Next-state logic: accept a start while idle, leave after the last slice
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:      if (INICIO) estado_d = PROCESSANDO;
            PROCESSANDO: if (ultima) estado_d = OCIOSO;
            default:     estado_d = OCIOSO;
        endcase
    end

    // Slice evaluation: pick slice k of the latched operands and merge the result into the accumulator
    always_comb begin
        base   = 32'(k_q) * 32'(FATIA);
        fat_a  = FATIA'(a_q >> base);
        fat_b  = FATIA'(b_q >> base);
        ultima = (k_q == ULTIMO);
        case (op_q)
            3'b000:  fat_r = fat_a & fat_b;
            3'b001:  fat_r = fat_a | fat_b;
            3'b010:  fat_r = fat_a ^ fat_b;
            3'b011:  fat_r = ~(fat_a & fat_b);
            3'b100:  fat_r = ~(fat_a | fat_b);
            3'b101:  fat_r = ~(fat_a ^ fat_b);
            3'b110:  fat_r = ~fat_a;
            default: fat_r = fat_a;
        endcase
        acc_novo = (acc_q & ~(MASCARA << base)) | (LARGURA'(fat_r) << base);
    end

    // Datapath next-state: operand capture, slice counter, accumulator and completion
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        k_d         = k_q;
        acc_d       = acc_q;
        resultado_d = resultado_q;
        pronto_d    = 1'b0;
`ifdef ULA_LOGICA_FLAGS_EN
        zero_d      = zero_q;
        paridade_d  = paridade_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (INICIO) begin
                    a_d   = A;
                    b_d   = B;
                    op_d  = OP;
                    k_d   = '0;
                    acc_d = '0;
                end
            end
            PROCESSANDO: begin
                acc_d = acc_novo;
                k_d   = ultima ? '0 : k_q + CW'(1);
                if (ultima) begin
                    // The final slice goes straight into RESULTADO on this same edge
                    resultado_d = acc_novo;
                    pronto_d    = 1'b1;
`ifdef ULA_LOGICA_FLAGS_EN
                    zero_d      = (acc_novo == '0);
                    paridade_d  = ^acc_novo;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            resultado_q <= '0;
            pronto_q    <= 1'b0;
`ifdef ULA_LOGICA_FLAGS_EN
            zero_q      <= 1'b0;
            paridade_q  <= 1'b0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            resultado_q <= resultado_d;
            pronto_q    <= pronto_d;
`ifdef ULA_LOGICA_FLAGS_EN
            zero_q      <= zero_d;
            paridade_q  <= paridade_d;
`endif
        end
    end

    // Outputs driven only from registers
    always_comb begin
        OCUPADO   = (estado_q == PROCESSANDO);
        PRONTO    = pronto_q;
        RESULTADO = resultado_q;
`ifdef ULA_LOGICA_FLAGS_EN
        ZERO      = zero_q;
        PARIDADE  = paridade_q;
`else
        ZERO      = 1'b0;
        PARIDADE  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_logica_serial.sv
// Testbench for logica_serial: a table of directed vectors, hand-written
// multi-cycle sequences and randomized back-to-back runs. Checks use a
// whole-word reference model, with the N=4 and N=1 configurations side by side.
module tb_logica_serial;

`ifdef ULA_LOGICA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio4, inicio16;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ocupado4, pronto4, zero4, par4;
    logic        ocupado16, pronto16, zero16, par16;
    logic [15:0] res4, res16;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    logica_serial #(.LARGURA(16), .FATIA(4)) dut4 (
        .CLK(clk), .RST(rst), .INICIO(inicio4), .OP(op), .A(a), .B(b),
        .OCUPADO(ocupado4), .PRONTO(pronto4), .RESULTADO(res4),
        .ZERO(zero4), .PARIDADE(par4)
    );

    logica_serial #(.LARGURA(16), .FATIA(16)) dut16 (
        .CLK(clk), .RST(rst), .INICIO(inicio16), .OP(op), .A(a), .B(b),
        .OCUPADO(ocupado16), .PRONTO(pronto16), .RESULTADO(res16),
        .ZERO(zero16), .PARIDADE(par16)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zero;
        logic        par;
    } vec_t;

    vec_t tab[8];

    function automatic logic [15:0] modelo(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string nome, input logic [15:0] atual, input logic [15:0] esp);
        total++;
        if (atual !== esp) $display("FAIL %s: got %h expected %h", nome, atual, esp);
        else passed++;
    endtask

    task automatic chk1(input string nome, input logic atual, input logic esp);
        total++;
        if (atual !== esp) $display("FAIL %s: got %b expected %b", nome, atual, esp);
        else passed++;
    endtask

    task automatic chkn(input string nome, input int atual, input int esp);
        total++;
        if (atual != esp) $display("FAIL %s: got %0d expected %0d", nome, atual, esp);
        else passed++;
    endtask

    // One operation on the N=4 unit, with latency, busy and pulse-width checks
    task automatic run_single(input logic [2:0] vop, input logic [15:0] va, input logic [15:0] vb, input string nome);
        logic [15:0] esp;
        int          lat;
        logic        busy_ok;
        esp = modelo(vop, va, vb);
        op = vop; a = va; b = vb; inicio4 = 1'b1;
        tick();
        inicio4 = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        while (!pronto4 && lat < 20) begin
            busy_ok &= ocupado4;
            tick();
            lat++;
        end
        chkn({nome, " latencia"}, lat, 4);
        chk1({nome, " ocupado durante"}, busy_ok, 1'b1);
        chk1({nome, " ocupado no pronto"}, ocupado4, 1'b0);
        chk16({nome, " resultado"}, res4, esp);
        chk1({nome, " zero"}, zero4, FLAGS && (esp == 16'h0000));
        chk1({nome, " paridade"}, par4, FLAGS && (^esp));
        tick();
        chk1({nome, " pulso unico"}, pronto4, 1'b0);
        chk16({nome, " resultado mantido"}, res4, esp);
    endtask

    // INICIO held high on one unit with fresh random operands each cycle
    task automatic b2b(input bit sel, input int nops, input int n);
        logic [15:0] fila[$];
        logic [15:0] esp, res;
        logic        pr;
        int          gap, got, guard;
        op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        fila.push_back(modelo(op, a, b));
        if (sel) inicio16 = 1'b1; else inicio4 = 1'b1;
        gap = 0; got = 0; guard = 0;
        while (got < nops && guard < 2000) begin
            tick();
            guard++;
            gap++;
            pr  = sel ? pronto16 : pronto4;
            res = sel ? res16 : res4;
            if (pr) begin
                esp = (fila.size() > 0) ? fila.pop_front() : 16'hxxxx;
                chkn($sformatf("b2b n=%0d intervalo %0d", n, got), gap, n + 1);
                chk16($sformatf("b2b n=%0d resultado %0d", n, got), res, esp);
                gap = 0;
                got++;
            end
            op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
            if (pr && got < nops) fila.push_back(modelo(op, a, b));
            if (got == nops) begin
                inicio4 = 1'b0;
                inicio16 = 1'b0;
            end
        end
        chkn($sformatf("b2b n=%0d operacoes completas", n), got, nops);
        inicio4 = 1'b0;
        inicio16 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int          lat, cnt;
        logic [15:0] esp;

        tab[0] = '{3'b001, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0};
        tab[1] = '{3'b010, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0};
        tab[2] = '{3'b110, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0};
        tab[3] = '{3'b011, 16'hFFFF, 16'h000F, 16'hFFF0, 1'b0, 1'b0};
        tab[4] = '{3'b000, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b1};
        tab[5] = '{3'b100, 16'h0000, 16'h0001, 16'hFFFE, 1'b0, 1'b1};
        tab[6] = '{3'b101, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b0};
        tab[7] = '{3'b111, 16'h8001, 16'hFFFF, 16'h8001, 1'b0, 1'b0};

        rst = 1'b1; inicio4 = 1'b0; inicio16 = 1'b0; op = '0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk1("reset ocupado", ocupado4, 1'b0);
        chk1("reset pronto", pronto4, 1'b0);
        chk16("reset resultado", res4, 16'h0000);
        chk1("reset zero", zero4, 1'b0);
        chk1("reset paridade", par4, 1'b0);
        chk1("reset ocupado n1", ocupado16, 1'b0);
        chk16("reset resultado n1", res16, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            run_single(tab[i].op, tab[i].a, tab[i].b, $sformatf("tab%0d", i));
            chk16($sformatf("tab%0d resultado tabela", i), res4, tab[i].res);
            chk1($sformatf("tab%0d zero tabela", i), zero4, FLAGS && tab[i].zero);
            chk1($sformatf("tab%0d paridade tabela", i), par4, FLAGS && tab[i].par);
        end

        for (int i = 0; i < 6; i++)
            run_single(3'($urandom), 16'($urandom), 16'($urandom), $sformatf("rnd%0d", i));

        // Start request while busy is dropped, not queued
        op = 3'b000; a = 16'h1234; b = 16'hFFFF; inicio4 = 1'b1;
        tick();
        inicio4 = 1'b0;
        tick();
        inicio4 = 1'b1; a = 16'h0000;
        tick();
        inicio4 = 1'b0;
        lat = 2;
        while (!pronto4 && lat < 20) begin
            tick();
            lat++;
        end
        chkn("ocupado ignora latencia", lat, 4);
        chk16("ocupado ignora resultado", res4, 16'h1234);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pronto4 || ocupado4) cnt++;
        end
        chkn("ocupado ignora sem segunda operacao", cnt, 0);

        // Operands changing every cycle after acceptance
        op = 3'b010; a = 16'h3C3C; b = 16'hFF00; inicio4 = 1'b1;
        esp = modelo(3'b010, 16'h3C3C, 16'hFF00);
        tick();
        inicio4 = 1'b0;
        lat = 0;
        while (!pronto4 && lat < 20) begin
            op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
            tick();
            lat++;
        end
        chkn("estabilidade latencia", lat, 4);
        chk16("estabilidade resultado", res4, esp);
        chk16("estabilidade constante", res4, 16'hC33C);
        tick();

        // Reset in the middle of an operation
        op = 3'b001; a = 16'h00F0; b = 16'h0F00; inicio4 = 1'b1;
        tick();
        inicio4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("reset meio ocupado", ocupado4, 1'b0);
        chk1("reset meio pronto", pronto4, 1'b0);
        chk16("reset meio resultado", res4, 16'h0000);
        chk1("reset meio zero", zero4, 1'b0);
        chk1("reset meio paridade", par4, 1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pronto4) cnt++;
        end
        chkn("reset meio sem pronto", cnt, 0);
        chk16("reset meio resultado mantido", res4, 16'h0000);
        run_single(3'b101, 16'hAAAA, 16'h5555, "pos reset");

        b2b(1'b0, 20, 4);
        b2b(1'b1, 20, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
